// File: rtl/cnn_acc_quant.sv
// cnn_acc_quant: accumulates the signed products of one kernel window onto a
// per-window bias, then rounds, shifts and saturates the sum to a signed
// activation held on a valid/ready output.
// Optional feature macro: CNN_ACC_RELU_EN (negative sums clamp to zero before
// rounding; only positive clipping is then reported on acc_sat).
module cnn_acc_quant #(
   parameter int unsigned PROD_W   = 21,
   parameter int unsigned ACC_W    = 32,
   parameter int unsigned OUT_W    = 8,
   parameter int unsigned SHIFT    = 13,
   parameter int unsigned MAX_TAPS = 1024,
   parameter int unsigned CNT_W    = 11
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic [PROD_W-1:0] prod_dat,
   input  logic              prod_vld,
   input  logic              prod_last,
   output logic              prod_rdy,
   input  logic [PROD_W-1:0] bias,
   output logic [OUT_W-1:0]  acc_dat,
   output logic              acc_vld,
   input  logic              acc_rdy,
   output logic              acc_sat,
   output logic              acc_ovf,
   output logic [CNT_W-1:0]  tap_cnt
);

   localparam int unsigned Q_W = ACC_W + 1;
   localparam logic signed [Q_W-1:0] Q_HALF = Q_W'(64'd1 << (SHIFT - 1));
   localparam logic signed [Q_W-1:0] Q_MAX  = Q_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [Q_W-1:0] Q_MIN  = Q_W'(-(1 << (OUT_W - 1)));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_FIN  = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_nx;
   logic [CNT_W-1:0]  cnt_nx;
   logic [OUT_W-1:0]  dat_nx;
   logic              sat_nx;
   logic              ovf_nx;

   logic              in_win_c;
   logic              beat_c;
   logic [CNT_W-1:0]  cnt_inc_c;
   logic              close_c;
   logic [ACC_W-1:0]  prod_ext_c;
   logic [ACC_W-1:0]  bias_ext_c;
   logic [ACC_W-1:0]  acc_sum_c;

   logic signed [Q_W-1:0] q_in_c;
   logic signed [Q_W-1:0] q_rnd_c;
   logic signed [Q_W-1:0] q_shr_c;
   logic [OUT_W-1:0]      q_dat_c;
   logic                  q_sat_c;

   // Beat qualification, tap counting and window-close detection
   always_comb begin
      in_win_c   = (state == S_IDLE) || (state == S_ACC);
      beat_c     = prod_vld & in_win_c;
      cnt_inc_c  = (state == S_IDLE) ? CNT_W'(1) : tap_cnt + CNT_W'(1);
      close_c    = beat_c & (prod_last | (cnt_inc_c == CNT_W'(MAX_TAPS)));
      prod_ext_c = {{(ACC_W - PROD_W){prod_dat[PROD_W-1]}}, prod_dat};
      bias_ext_c = {{(ACC_W - PROD_W){bias[PROD_W-1]}}, bias};
      acc_sum_c  = ((state == S_IDLE) ? bias_ext_c : acc) + prod_ext_c;
   end

   // Round-half-up, arithmetic shift and saturation of the window sum
   always_comb begin
`ifdef CNN_ACC_RELU_EN
      q_in_c = acc[ACC_W-1] ? '0 : {acc[ACC_W-1], acc};
`else
      q_in_c = {acc[ACC_W-1], acc};
`endif
      q_rnd_c = q_in_c + Q_HALF;
      q_shr_c = q_rnd_c >>> SHIFT;
      q_dat_c = q_shr_c[OUT_W-1:0];
      q_sat_c = 1'b0;
      if (q_shr_c > Q_MAX) begin
         q_dat_c = Q_MAX[OUT_W-1:0];
         q_sat_c = 1'b1;
      end else if (q_shr_c < Q_MIN) begin
         q_dat_c = Q_MIN[OUT_W-1:0];
         q_sat_c = 1'b1;
      end
   end

   // Next-state and next-register values; every register holds by default
   always_comb begin
      state_nx = state;
      acc_nx   = acc;
      cnt_nx   = tap_cnt;
      dat_nx   = acc_dat;
      sat_nx   = acc_sat;
      ovf_nx   = acc_ovf;
      case (state)
         S_IDLE, S_ACC: begin
            if (beat_c) begin
               acc_nx = acc_sum_c;
               cnt_nx = cnt_inc_c;
               if (close_c) begin
                  state_nx = S_FIN;
                  ovf_nx   = ~prod_last;
               end else begin
                  state_nx = S_ACC;
               end
            end
         end
         S_FIN: begin
            dat_nx   = q_dat_c;
            sat_nx   = q_sat_c;
            state_nx = S_OUT;
         end
         S_OUT: begin
            if (acc_rdy) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State and registered outputs; handshake flags are decoded from next state
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state    <= S_IDLE;
         acc      <= '0;
         tap_cnt  <= '0;
         acc_dat  <= '0;
         acc_sat  <= 1'b0;
         acc_ovf  <= 1'b0;
         acc_vld  <= 1'b0;
         prod_rdy <= 1'b1;
      end else begin
         state    <= state_nx;
         acc      <= acc_nx;
         tap_cnt  <= cnt_nx;
         acc_dat  <= dat_nx;
         acc_sat  <= sat_nx;
         acc_ovf  <= ovf_nx;
         acc_vld  <= (state_nx == S_OUT);
         prod_rdy <= (state_nx == S_IDLE) || (state_nx == S_ACC);
      end
   end

endmodule
